// File: rtl/commit_monitor.sv
// commit_monitor
//   Receive side of the core's commit interface. Commit records arrive over a
//   valid/ready handshake into a small FIFO and are drained one per cycle into
//   a shadow 32 x 64 integer register file. Also keeps cycle / instruction /
//   skip counters and catches the 0x6b trap instruction.
//
// Ports
//   clk, rst         : sole clock; synchronous active-high reset
//   i_cmt_valid      : commit record offered
//   o_cmt_ready      : record accepted when valid && ready at posedge
//   i_cmt_pc/inst    : PC and instruction word of the committed instruction
//   i_cmt_skip       : record marked skip (MMIO etc.)
//   i_cmt_wen/wdest/wdata : destination write (wdest legal range 0..31)
//   i_gpr_idx        : shadow register read index
//   o_gpr_rdata      : shadow[i_gpr_idx], combinational, x0 reads 0
//   o_trap, o_trap_code, o_trap_pc : sticky trap report
//   o_cycle_cnt      : cycles spent in RUN
//   o_instr_cnt      : records drained
//   o_skip_cnt       : drained records with skip set
//   o_err            : sticky, a drained record wrote an out-of-range wdest
module commit_monitor #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmt_valid,
  output logic        o_cmt_ready,
  input  logic [63:0] i_cmt_pc,
  input  logic [31:0] i_cmt_inst,
  input  logic        i_cmt_skip,
  input  logic        i_cmt_wen,
  input  logic [7:0]  i_cmt_wdest,
  input  logic [63:0] i_cmt_wdata,
  input  logic [4:0]  i_gpr_idx,
  output logic [63:0] o_gpr_rdata,
  output logic        o_trap,
  output logic [7:0]  o_trap_code,
  output logic [63:0] o_trap_pc,
  output logic [63:0] o_cycle_cnt,
  output logic [63:0] o_instr_cnt,
  output logic [63:0] o_skip_cnt,
  output logic        o_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {RUN, TRAPPED} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Only the opcode field matters for trap detection, so the FIFO keeps a
  // single trap flag per entry instead of the full instruction word.
  logic [63:0] q_pc    [DEPTH];
  logic        q_trap  [DEPTH];
  logic        q_skip  [DEPTH];
  logic        q_wen   [DEPTH];
  logic [7:0]  q_wdest [DEPTH];
  logic [63:0] q_wdata [DEPTH];

  logic [63:0] shadow  [32];

  logic        push;
  logic        pop;
  logic [63:0] h_pc;
  logic        h_trap;
  logic        h_skip;
  logic        h_wen;
  logic [7:0]  h_wdest;
  logic [63:0] h_wdata;
  logic        unused_inst;

  function automatic logic is_trap(input logic [31:0] inst);
    return inst[6:0] == 7'h6b;
  endfunction

  assign unused_inst = ^i_cmt_inst[31:7];

  assign o_cmt_ready = !rst && (state == RUN) && (count < FULL);
  assign push        = i_cmt_valid && o_cmt_ready;
  // A record pushed into an empty FIFO is only visible to pop next cycle.
  assign pop         = (state == RUN) && (count != '0);

  assign h_pc    = q_pc[rd_ptr];
  assign h_trap  = q_trap[rd_ptr];
  assign h_skip  = q_skip[rd_ptr];
  assign h_wen   = q_wen[rd_ptr];
  assign h_wdest = q_wdest[rd_ptr];
  assign h_wdata = q_wdata[rd_ptr];

  assign o_gpr_rdata = (i_gpr_idx == 5'd0) ? 64'd0 : shadow[i_gpr_idx];

  // FIFO storage: payload only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= i_cmt_pc;
      q_trap[wr_ptr]  <= is_trap(i_cmt_inst);
      q_skip[wr_ptr]  <= i_cmt_skip;
      q_wen[wr_ptr]   <= i_cmt_wen;
      q_wdest[wr_ptr] <= i_cmt_wdest;
      q_wdata[wr_ptr] <= i_cmt_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_trap      <= 1'b0;
      o_trap_code <= 8'd0;
      o_trap_pc   <= 64'd0;
      o_cycle_cnt <= 64'd0;
      o_instr_cnt <= 64'd0;
      o_skip_cnt  <= 64'd0;
      o_err       <= 1'b0;
      for (int i = 0; i < 32; i++) shadow[i] <= 64'd0;
    end else if (state == RUN) begin
      o_cycle_cnt <= o_cycle_cnt + 64'd1;

      if (pop) begin
        if (h_wen && (h_wdest[7:5] == 3'd0) && (h_wdest[4:0] != 5'd0))
          shadow[h_wdest[4:0]] <= h_wdata;
        if (h_wen && (h_wdest[7:5] != 3'd0))
          o_err <= 1'b1;
        o_instr_cnt <= o_instr_cnt + 64'd1;
        if (h_skip)
          o_skip_cnt <= o_skip_cnt + 64'd1;
      end

      if (pop && h_trap) begin
        // x10 is sampled before this record's own shadow write lands.
        o_trap      <= 1'b1;
        o_trap_pc   <= h_pc;
        o_trap_code <= shadow[10][7:0];
        state       <= TRAPPED;
        // Anything still queued behind the trap is dropped.
        count       <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)
          count <= count + CNT_W'(1);
        else if (!push && pop)
          count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_commit_monitor.sv
module tb_commit_monitor;

  logic        clk;
  logic        rst;
  logic        i_cmt_valid;
  logic        o_cmt_ready;
  logic [63:0] i_cmt_pc;
  logic [31:0] i_cmt_inst;
  logic        i_cmt_skip;
  logic        i_cmt_wen;
  logic [7:0]  i_cmt_wdest;
  logic [63:0] i_cmt_wdata;
  logic [4:0]  i_gpr_idx;
  logic [63:0] o_gpr_rdata;
  logic        o_trap;
  logic [7:0]  o_trap_code;
  logic [63:0] o_trap_pc;
  logic [63:0] o_cycle_cnt;
  logic [63:0] o_instr_cnt;
  logic [63:0] o_skip_cnt;
  logic        o_err;

  int vectors;
  int miscompares;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] TRAP = 32'h0000_006b;

  commit_monitor #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_cmt_valid (i_cmt_valid),
    .o_cmt_ready (o_cmt_ready),
    .i_cmt_pc    (i_cmt_pc),
    .i_cmt_inst  (i_cmt_inst),
    .i_cmt_skip  (i_cmt_skip),
    .i_cmt_wen   (i_cmt_wen),
    .i_cmt_wdest (i_cmt_wdest),
    .i_cmt_wdata (i_cmt_wdata),
    .i_gpr_idx   (i_gpr_idx),
    .o_gpr_rdata (o_gpr_rdata),
    .o_trap      (o_trap),
    .o_trap_code (o_trap_code),
    .o_trap_pc   (o_trap_pc),
    .o_cycle_cnt (o_cycle_cnt),
    .o_instr_cnt (o_instr_cnt),
    .o_skip_cnt  (o_skip_cnt),
    .o_err       (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_gpr(input string tag, input logic [4:0] idx, input logic [63:0] exp);
    i_gpr_idx = idx;
    #1;
    chk(tag, o_gpr_rdata, exp);
  endtask

  // Presents one record for exactly one clock edge; valid is left high.
  task automatic push(input logic [63:0] pc, input logic [31:0] inst, input logic skip,
                      input logic wen, input logic [7:0] wdest, input logic [63:0] wdata);
    i_cmt_valid = 1'b1;
    i_cmt_pc    = pc;
    i_cmt_inst  = inst;
    i_cmt_skip  = skip;
    i_cmt_wen   = wen;
    i_cmt_wdest = wdest;
    i_cmt_wdata = wdata;
    step();
  endtask

  task automatic idle();
    i_cmt_valid = 1'b0;
    step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    i_cmt_valid = 1'b0;
    i_cmt_pc    = 64'd0;
    i_cmt_inst  = NOP;
    i_cmt_skip  = 1'b0;
    i_cmt_wen   = 1'b0;
    i_cmt_wdest = 8'd0;
    i_cmt_wdata = 64'd0;
    i_gpr_idx   = 5'd0;

    // Reset
    step();
    step();
    chk("ready_in_rst", {63'd0, o_cmt_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {63'd0, o_cmt_ready}, 64'd1);
    chk("trap_rst", {63'd0, o_trap}, 64'd0);
    chk("cycle_rst", o_cycle_cnt, 64'd0);
    chk("instr_rst", o_instr_cnt, 64'd0);
    chk("err_rst", {63'd0, o_err}, 64'd0);

    // Three writes back to back
    push(64'h1000, NOP, 1'b0, 1'b1, 8'd5, 64'h11);
    push(64'h1004, NOP, 1'b0, 1'b1, 8'd6, 64'h22);
    push(64'h1008, NOP, 1'b0, 1'b1, 8'd7, 64'h33);
    idle();
    chk_gpr("x5", 5'd5, 64'h11);
    chk_gpr("x6", 5'd6, 64'h22);
    chk_gpr("x7", 5'd7, 64'h33);
    chk("instr_3", o_instr_cnt, 64'd3);
    chk("cycle_4", o_cycle_cnt, 64'd4);

    // x0 write is ignored; out-of-range wdest flags error without writing
    push(64'h100c, NOP, 1'b0, 1'b1, 8'd0, 64'hFF);
    idle();
    chk_gpr("x0", 5'd0, 64'd0);
    chk("err_x0", {63'd0, o_err}, 64'd0);
    push(64'h1010, NOP, 1'b0, 1'b1, 8'h25, 64'hDEAD);
    idle();
    chk("err_bad", {63'd0, o_err}, 64'd1);
    chk_gpr("x5_kept", 5'd5, 64'h11);
    chk("instr_5", o_instr_cnt, 64'd5);
    chk("cycle_8", o_cycle_cnt, 64'd8);

    // Trap with x10 = 0x2A, followed by two trailing records
    push(64'h1014, NOP, 1'b0, 1'b1, 8'd10, 64'h2A);
    push(64'h8000_0100, TRAP, 1'b0, 1'b0, 8'd0, 64'd0);
    push(64'h8000_0104, NOP, 1'b0, 1'b1, 8'd11, 64'h77);
    push(64'h8000_0108, NOP, 1'b0, 1'b1, 8'd12, 64'h88);
    idle();
    chk("trap", {63'd0, o_trap}, 64'd1);
    chk("trap_code", {56'd0, o_trap_code}, 64'h2A);
    chk("trap_pc", o_trap_pc, 64'h8000_0100);
    chk("ready_trapped", {63'd0, o_cmt_ready}, 64'd0);
    chk("instr_trap", o_instr_cnt, 64'd7);
    chk("cycle_trap", o_cycle_cnt, 64'd11);
    chk_gpr("x11_dropped", 5'd11, 64'd0);
    chk_gpr("x12_dropped", 5'd12, 64'd0);
    idle();
    idle();
    chk("cycle_frozen", o_cycle_cnt, 64'd11);

    // Reset out of TRAPPED
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("ready_rst2", {63'd0, o_cmt_ready}, 64'd1);
    chk("trap_rst2", {63'd0, o_trap}, 64'd0);
    chk("code_rst2", {56'd0, o_trap_code}, 64'd0);
    chk("pc_rst2", o_trap_pc, 64'd0);
    chk("cycle_rst2", o_cycle_cnt, 64'd0);
    chk("err_rst2", {63'd0, o_err}, 64'd0);
    chk_gpr("x10_rst2", 5'd10, 64'd0);

    // Skip pattern 1,0,1,1,0
    push(64'h2000, NOP, 1'b1, 1'b0, 8'd0, 64'd0);
    push(64'h2004, NOP, 1'b0, 1'b0, 8'd0, 64'd0);
    push(64'h2008, NOP, 1'b1, 1'b0, 8'd0, 64'd0);
    push(64'h200c, NOP, 1'b1, 1'b0, 8'd0, 64'd0);
    push(64'h2010, NOP, 1'b0, 1'b0, 8'd0, 64'd0);
    idle();
    chk("skip_cnt", o_skip_cnt, 64'd3);
    chk("instr_skip", o_instr_cnt, 64'd5);
    chk("cycle_skip", o_cycle_cnt, 64'd6);

    // Continuous stream with a trap behind three writes; valid held high
    chk("ready_s0", {63'd0, o_cmt_ready}, 64'd1);
    push(64'h3000, NOP, 1'b0, 1'b1, 8'd1, 64'h101);
    chk("ready_s1", {63'd0, o_cmt_ready}, 64'd1);
    push(64'h3004, NOP, 1'b0, 1'b1, 8'd2, 64'h202);
    chk("ready_s2", {63'd0, o_cmt_ready}, 64'd1);
    push(64'h3008, NOP, 1'b0, 1'b1, 8'd3, 64'h303);
    chk("ready_s3", {63'd0, o_cmt_ready}, 64'd1);
    push(64'h300c, TRAP, 1'b0, 1'b0, 8'd0, 64'd0);
    chk("ready_s4", {63'd0, o_cmt_ready}, 64'd1);
    push(64'h3010, NOP, 1'b0, 1'b1, 8'd4, 64'h404);
    chk("ready_s5", {63'd0, o_cmt_ready}, 64'd0);
    push(64'h3014, NOP, 1'b0, 1'b1, 8'd5, 64'h505);
    i_cmt_valid = 1'b0;
    chk("instr_stream", o_instr_cnt, 64'd9);
    chk("cycle_stream", o_cycle_cnt, 64'd11);
    chk("trap_pc_stream", o_trap_pc, 64'h300c);
    chk("trap_code_stream", {56'd0, o_trap_code}, 64'd0);
    chk_gpr("x1_stream", 5'd1, 64'h101);
    chk_gpr("x3_stream", 5'd3, 64'h303);
    chk_gpr("x4_stream", 5'd4, 64'd0);

    // Reset while records are in flight
    rst = 1'b1;
    step();
    rst = 1'b0;
    push(64'h4000, NOP, 1'b0, 1'b1, 8'd3, 64'h55);
    rst         = 1'b1;
    i_cmt_wdest = 8'd4;
    i_cmt_wdata = 64'h66;
    #1;
    chk("ready_rst3_hi", {63'd0, o_cmt_ready}, 64'd0);
    step();
    rst         = 1'b0;
    i_cmt_valid = 1'b0;
    #1;
    chk("ready_rst3", {63'd0, o_cmt_ready}, 64'd1);
    chk("instr_rst3", o_instr_cnt, 64'd0);
    chk("cycle_rst3", o_cycle_cnt, 64'd0);
    idle();
    chk_gpr("x3_rst3", 5'd3, 64'd0);
    chk_gpr("x4_rst3", 5'd4, 64'd0);
    chk("instr_rst3_b", o_instr_cnt, 64'd0);
    chk("cycle_rst3_b", o_cycle_cnt, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
